dcache_snoop_responder: RTL and testbench

//  Cache-side end of the coherence bus: answers snoops issued by the memory controller for one dcache.
//  Tag-matches ccsnoopaddr against this cache's frames and raises cctrans on a dirty (M) hit.
//  On a dirty hit, supplies both block words on the snoop data path. Then downgrades M->S, or invalidates on ccinv.
//  One instance per dcache; frame arrays stay in the dcache, accessed through the lookup/update ports below.

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/snoop_tag_match.sv | 26 ++
 rtl/dcache_snoop_responder.sv | 105 ++++++++++
 tb/tb_dcache_snoop_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared cpu/cache types plus the dcache snoop responder state encoding.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic [25:0] tag;
    logic [2:0]  idx;
    logic        blkoff;
    logic [1:0]  bytoff;
  } dcachef_t;
  localparam int SNP_BLK_WORDS = 2;
  typedef logic [2:0] snoop_state_t;
  localparam snoop_state_t IDLE = 3'd0;
  localparam snoop_state_t SUP0 = 3'd1;
  localparam snoop_state_t SUP1 = 3'd2;
  localparam snoop_state_t FIN  = 3'd3;
  localparam snoop_state_t HOLD = 3'd4;
endpackage

// File: rtl/snoop_tag_match.sv
// snoop_tag_match: compares a snooped tag against every way of one set; the lowest matching way wins.
module snoop_tag_match #(
  parameter int WAYS  = 2,
  parameter int TAG_W = 26,
  parameter int WW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [TAG_W-1:0]      tag,
  input  logic [WAYS*TAG_W-1:0] frm_tag,
  input  logic [WAYS-1:0]       frm_valid,
  input  logic [WAYS-1:0]       frm_dirty,
  output logic                  hit,
  output logic                  hit_dirty,
  output logic [WW-1:0]         hit_way
);
  always_comb begin
    hit       = 1'b0;
    hit_dirty = 1'b0;
    hit_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (frm_valid[w] && frm_tag[w*TAG_W +: TAG_W] == tag) begin
        hit       = 1'b1;
        hit_dirty = frm_dirty[w];
        hit_way   = WW'(w);
      end
  end
endmodule

// File: rtl/dcache_snoop_responder.sv
// dcache_snoop_responder: answers coherence snoops for one dcache, supplying dirty blocks and downgrading/invalidating lines.
// Optional SNOOP_STATS_EN adds snp_hits/snp_supplies counters.
module dcache_snoop_responder
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int TAG_W = 26,
  localparam int IW   = $clog2(SETS),
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          ccwait,
  input  logic [31:0]                   ccsnoopaddr,
  input  logic                          ccinv,
  input  logic                          dwait,
  output logic                          cctrans,
  output logic                          snp_active,
  output logic [31:0]                   snp_daddr,
  output logic [31:0]                   snp_dstore,
  output logic [IW-1:0]                 snp_idx,
  input  logic [WAYS*TAG_W-1:0]         frm_tag,
  input  logic [WAYS-1:0]               frm_valid,
  input  logic [WAYS-1:0]               frm_dirty,
  input  logic [WAYS*SNP_BLK_WORDS*32-1:0] frm_data,
  output logic                          upd_en,
  output logic [WW-1:0]                 upd_way,
  output logic                          upd_inv
`ifdef SNOOP_STATS_EN
  ,
  output logic [31:0]                   snp_hits,
  output logic [31:0]                   snp_supplies
`endif
);
  snoop_state_t state, nxt;
  word_t        addr_l;
  logic [WW-1:0] way_l, hit_way;
  logic         hit_l, inv_pend, inv_done, hit, hit_dirty, idle, hold_inv;

  snoop_tag_match #(.WAYS(WAYS), .TAG_W(TAG_W), .WW(WW)) u_match (
    .tag       (ccsnoopaddr[31 -: TAG_W]),
    .frm_tag   (frm_tag),
    .frm_valid (frm_valid),
    .frm_dirty (frm_dirty),
    .hit       (hit),
    .hit_dirty (hit_dirty),
    .hit_way   (hit_way)
  );

  assign snp_idx    = ccsnoopaddr[3 +: IW];
  assign idle       = state == IDLE;
  assign snp_active = state == SUP0 || state == SUP1;
  // cctrans must be valid in the address cycle itself, so IDLE drives it straight from the live compare
  assign cctrans    = idle ? ccwait & hit_dirty : snp_active || state == FIN;
  assign snp_daddr  = snp_active ? addr_l | {29'b0, state == SUP1, 2'b00} : '0;
  assign snp_dstore = snp_active ? frm_data[way_l*64 + (state == SUP1 ? 32 : 0) +: 32] : '0;
  assign hold_inv   = state == HOLD && hit_l && inv_pend && !inv_done;
  assign upd_en     = state == FIN || hold_inv;
  assign upd_way    = upd_en ? way_l : '0;
  assign upd_inv    = upd_en && inv_pend;

  always_comb begin
    nxt = state;
    if (idle && ccwait) nxt = hit_dirty ? SUP0 : HOLD;
    else if (snp_active && !ccwait) nxt = IDLE;
    else if (state == SUP0 && !dwait) nxt = SUP1;
    else if (state == SUP1 && !dwait) nxt = FIN;
    else if (state == FIN) nxt = HOLD;
    else if (state == HOLD && !ccwait) nxt = IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      addr_l   <= '0;
      way_l    <= '0;
      hit_l    <= 1'b0;
      inv_pend <= 1'b0;
      inv_done <= 1'b0;
    end else begin
      state <= nxt;
      if (idle && ccwait) begin
        addr_l <= ccsnoopaddr & ~32'h7;
        way_l  <= hit_way;
        hit_l  <= hit;
      end
      // inv_done lets a late ccinv after a plain downgrade still invalidate, but only once
      inv_pend <= (nxt == IDLE) ? 1'b0 : inv_pend | (ccinv & ccwait);
      inv_done <= (nxt == IDLE) ? 1'b0 : inv_done | upd_inv;
    end
  end

`ifdef SNOOP_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snp_hits     <= '0;
      snp_supplies <= '0;
    end else begin
      if (idle && ccwait && hit) snp_hits <= snp_hits + 32'd1;
      if (state == SUP1 && nxt == FIN) snp_supplies <= snp_supplies + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_snoop_responder.sv
// tb_dcache_snoop_responder: randomized scoreboard bench with a line-level coherence reference model.
module tb_dcache_snoop_responder;
  logic        CLK = 1'b0, nRST = 1'b0, ccwait = 1'b0, ccinv = 1'b0, dwait = 1'b1;
  logic [31:0] ccsnoopaddr = '0;
  logic        cctrans, snp_active, upd_en, upd_inv;
  logic [31:0] snp_daddr, snp_dstore;
  logic [2:0]  snp_idx;
  logic [0:0]  upd_way;
  logic [51:0] frm_tag;
  logic [1:0]  frm_valid, frm_dirty;
  logic [127:0] frm_data;
`ifdef SNOOP_STATS_EN
  logic [31:0] snp_hits, snp_supplies;
`endif

  dcache_snoop_responder dut (
    .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccsnoopaddr(ccsnoopaddr), .ccinv(ccinv),
    .dwait(dwait), .cctrans(cctrans), .snp_active(snp_active), .snp_daddr(snp_daddr),
    .snp_dstore(snp_dstore), .snp_idx(snp_idx), .frm_tag(frm_tag), .frm_valid(frm_valid),
    .frm_dirty(frm_dirty), .frm_data(frm_data), .upd_en(upd_en), .upd_way(upd_way),
    .upd_inv(upd_inv)
`ifdef SNOOP_STATS_EN
    , .snp_hits(snp_hits), .snp_supplies(snp_supplies)
`endif
  );

  always #5 CLK = ~CLK;

  logic [25:0] tg[8][2];
  logic [63:0] dat[8][2];
  bit          e_v[8][2], e_d[8][2], m_v[8][2], m_d[8][2];
  logic [63:0] wq[$];
  logic [1:0]  uq[$];
  int          n_chk = 0, n_err = 0, m_hits = 0, m_sup = 0;
  logic [25:0] pool[4] = '{26'hABC, 26'h1, 26'h3FFFFFF, 26'h2AAAAAA};

  // the dcache side: frame arrays indexed by the live snoop address
  always_comb begin
    frm_tag = '0; frm_valid = '0; frm_dirty = '0; frm_data = '0;
    for (int w = 0; w < 2; w++) begin
      frm_tag[w*26 +: 26]  = tg[ccsnoopaddr[5:3]][w];
      frm_valid[w]         = e_v[ccsnoopaddr[5:3]][w];
      frm_dirty[w]         = e_d[ccsnoopaddr[5:3]][w];
      frm_data[w*64 +: 64] = dat[ccsnoopaddr[5:3]][w];
    end
  end

  always @(posedge CLK)
    if (nRST && upd_en) begin
      e_d[snp_idx][upd_way] <= 1'b0;
      if (upd_inv) e_v[snp_idx][upd_way] <= 1'b0;
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s: got %h expected no event", nm, act);
  endtask

  always @(negedge CLK)
    if (nRST) begin
      if (snp_active && !dwait) begin
        if (wq.size() == 0) unexpected("word", {snp_daddr, snp_dstore});
        else chk("word", {snp_daddr, snp_dstore}, wq.pop_front());
      end
      if (upd_en) begin
        if (uq.size() == 0) unexpected("upd", {upd_way, upd_inv});
        else chk("upd", {upd_way, upd_inv}, uq.pop_front());
      end
      if (!snp_active) chk("inactive_data_zero", {snp_daddr, snp_dstore}, 64'h0);
    end

  task automatic tick;
    @(posedge CLK);
    #1 ccinv = 1'b0;
  endtask

  task automatic set_line(input int s, input int w, input logic [25:0] t, input bit v, input bit d,
                          input logic [63:0] x);
    tg[s][w] = t; dat[s][w] = x;
    e_v[s][w] = v; m_v[s][w] = v;
    e_d[s][w] = d; m_d[s][w] = d;
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_ctl"}, {cctrans, snp_active, upd_en, upd_inv, upd_way}, 64'h0);
    chk({nm, "_data"}, {snp_daddr, snp_dstore}, 64'h0);
  endtask

  // mode: 0 no ccinv, 1 with the address, 2 in the first cycle after, 3 later in HOLD
  task automatic snoop(input logic [31:0] a, input int mode, input bit abort, input int d0,
                       input int d1, input bit rst_mid);
    int s, hw;
    bit dirty;
    s = int'(a[5:3]);
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (hw < 0 && m_v[s][w] && tg[s][w] == a[31:6]) hw = w;
    dirty = hw >= 0 && m_d[s][hw];
    if (hw >= 0) m_hits++;
    if (dirty && !abort) begin
      wq.push_back({a & ~32'h7, dat[s][hw][31:0]});
      if (!rst_mid) begin
        wq.push_back({(a & ~32'h7) | 32'h4, dat[s][hw][63:32]});
        uq.push_back({hw[0], mode == 1 || mode == 2});
        if (mode == 3) uq.push_back({hw[0], 1'b1});
        m_d[s][hw] = 1'b0;
        if (mode != 0) m_v[s][hw] = 1'b0;
        m_sup++;
      end
    end else if (hw >= 0 && !dirty && mode != 0) begin
      uq.push_back({hw[0], 1'b1});
      m_v[s][hw] = 1'b0;
    end
    @(posedge CLK);
    #1 ccwait = 1'b1; ccsnoopaddr = a; ccinv = (mode == 1); dwait = 1'b1;
    #1 chk("cctrans_addr_cycle", cctrans, dirty);
    tick;
    ccinv = (mode == 2);
    if (dirty) begin
      chk("cctrans_sup0", {cctrans, snp_active}, 2'b11);
      if (abort) begin
        ccwait = 1'b0;
        tick;
        check_quiet("abort");
        tick;
        return;
      end
      repeat (d0) tick;
      dwait = 1'b0;
      tick;
      dwait = 1'b1;
      if (rst_mid) begin
        chk("sup1_active", snp_active, 1'b1);
        nRST = 1'b0; ccwait = 1'b0;
        #1 check_quiet("mid_reset");
        tick;
        nRST = 1'b1;
        #1 check_quiet("after_reset");
        m_hits = 0; m_sup = 0;
        repeat (2) tick;
        return;
      end
      repeat (d1) tick;
      dwait = 1'b0;
      tick;
      dwait = 1'b1;
      chk("fin_cctrans", {cctrans, snp_active}, 2'b10);
      tick;
    end else chk("hold_quiet", {cctrans, snp_active}, 2'b00);
    if (mode == 3) ccinv = 1'b1;
    repeat (4) tick;
    ccwait = 1'b0;
    tick;
    check_quiet("back_idle");
  endtask

  initial begin
    logic [31:0] a;
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) set_line(s, w, 26'h0, 1'b0, 1'b0, 64'h0);
    repeat (3) @(posedge CLK);
    #1 check_quiet("in_reset");
    nRST = 1'b1;
    #1 check_quiet("reset_state");
`ifdef SNOOP_STATS_EN
    chk("stats_reset", {snp_hits, snp_supplies}, 64'h0);
`endif
    set_line(3, 1, 26'hABC, 1'b1, 1'b1, {32'hDEAD0001, 32'hBEEF0000});
    snoop(32'h0002AF18, 0, 1'b0, 1, 1, 1'b1);
    snoop(32'h0002AF18, 0, 1'b0, 2, 2, 1'b0);
    snoop(32'h0002AF18, 0, 1'b0, 1, 0, 1'b0);
    set_line(3, 1, 26'hABC, 1'b1, 1'b1, {32'hDEAD0001, 32'hBEEF0000});
    snoop(32'h0002AF18, 2, 1'b0, 0, 1, 1'b0);
    set_line(3, 1, 26'hABC, 1'b1, 1'b0, {32'hDEAD0001, 32'hBEEF0000});
    snoop(32'h0002AF18, 3, 1'b0, 0, 0, 1'b0);
    set_line(3, 1, 26'hABC, 1'b0, 1'b1, {32'hDEAD0001, 32'hBEEF0000});
    snoop(32'h0002AF18, 1, 1'b0, 0, 0, 1'b0);
    set_line(3, 1, 26'hABC, 1'b1, 1'b1, {32'hDEAD0001, 32'hBEEF0000});
    snoop(32'h0002AF18, 0, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if ($urandom % 2 == 0)
        set_line(int'($urandom % 8), int'($urandom % 2), pool[$urandom % 4], ($urandom % 4) != 0,
                 ($urandom % 2) != 0, {$urandom, $urandom});
      a = {pool[$urandom % 4], 3'($urandom % 8), 3'($urandom % 8)};
      snoop(a, int'($urandom % 4), ($urandom % 6) == 0, int'($urandom % 3), int'($urandom % 3), 1'b0);
    end
    repeat (3) tick;
    chk("words_left", 64'(wq.size()), 64'h0);
    chk("upds_left", 64'(uq.size()), 64'h0);
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) chk("frame_state", {e_v[s][w], e_d[s][w]}, {m_v[s][w], m_d[s][w]});
`ifdef SNOOP_STATS_EN
    chk("snp_hits", snp_hits, 64'(m_hits));
    chk("snp_supplies", snp_supplies, 64'(m_sup));
`endif
    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end
endmodule
